// File: rtl/reg_bank_p_pkg.sv
// Shared definitions for the operand register bank.
// Holds the port P write-mode encodings and the default bus/bank sizes
// shared with the ALU.
package reg_bank_p_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_DEPTH  = 16;

    // Port P write modes (endwreg)
    localparam logic [1:0] WMODE_FULL = 2'b00;  // replace whole word
    localparam logic [1:0] WMODE_LO   = 2'b01;  // replace low half only
    localparam logic [1:0] WMODE_HI   = 2'b10;  // replace high half only
    localparam logic [1:0] WMODE_SET  = 2'b11;  // OR data into the word

endpackage

// File: rtl/reg_bank_wmerge.sv
// Port P write merge.
// Purely combinational: given the current register contents, the port P
// write data and the write mode, produce the value the register holds
// after the write.
// Ports:
//   old_val  in   current register contents
//   in_data  in   port P write data
//   mode     in   write mode (WMODE_*)
//   new_val  out  post-write register value
module reg_bank_wmerge
    import reg_bank_p_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] new_val
);

    localparam int H = DATA_W / 2;

    always_comb begin
        new_val = in_data;
        case (mode)
            WMODE_FULL: new_val = in_data;
            WMODE_LO:   new_val = {old_val[DATA_W-1:H], in_data[H-1:0]};
            WMODE_HI:   new_val = {in_data[DATA_W-1:H], old_val[H-1:0]};
            WMODE_SET:  new_val = old_val | in_data;
            default:    new_val = in_data;
        endcase
    end

endmodule

// File: rtl/reg_bank_p.sv
// Dual-write-port operand register bank.
// Port P (host) writes with four merge modes; port W (ALU write-back)
// writes full words through a valid/ready handshake and is stalled when
// it targets the same register as a simultaneous port P write.
// Two registered read ports (A, B) with load enable, constant injection
// and same-edge write forwarding; each has a one-cycle valid flag.
// Ports:
//   clock, reset            clock (rising edge), async active-low reset
//   regwen/inA/selwreg/endwreg   port P write
//   wbvalid/wbsel/wbdata/wbready port W write handshake
//   seloutA/B, enrregA/B, cnstA/B read selects, load enables, constants
//   outA/B, rvalidA/B       registered operands and valid flags
module reg_bank_p
    import reg_bank_p_pkg::*;
#(
    parameter int              DATA_W    = DEF_DATA_W,
    parameter int              DEPTH     = DEF_DEPTH,
    parameter logic [DATA_W-1:0] CNST_A  = '0,
    parameter logic [DATA_W-1:0] CNST_B  = {{(DATA_W-1){1'b0}}, 1'b1},
    parameter bit              ZERO_REG0 = 1'b0,
    localparam int             SEL_W     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              regwen,
    input  logic [DATA_W-1:0] inA,
    input  logic [SEL_W-1:0]  selwreg,
    input  logic [1:0]        endwreg,
    input  logic              wbvalid,
    input  logic [SEL_W-1:0]  wbsel,
    input  logic [DATA_W-1:0] wbdata,
    output logic              wbready,
    input  logic [SEL_W-1:0]  seloutA,
    input  logic [SEL_W-1:0]  seloutB,
    input  logic              enrregA,
    input  logic              enrregB,
    input  logic              cnstA,
    input  logic              cnstB,
    output logic [DATA_W-1:0] outA,
    output logic [DATA_W-1:0] outB,
    output logic              rvalidA,
    output logic              rvalidB
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] p_merged;
    logic              wb_fire;

    logic [DATA_W-1:0] outa_q, outa_d;
    logic [DATA_W-1:0] outb_q, outb_d;
    logic              rvalida_q, rvalida_d;
    logic              rvalidb_q, rvalidb_d;

    // Port P has priority on a same-register collision; port W is held
    // off until the collision clears. Never ready while in reset.
    assign wbready = reset & ~(regwen & wbvalid & (selwreg == wbsel));
    assign wb_fire = wbvalid & wbready;

    reg_bank_wmerge #(
        .DATA_W (DATA_W)
    ) u_wmerge (
        .old_val (regs_q[selwreg]),
        .in_data (inA),
        .mode    (endwreg),
        .new_val (p_merged)
    );

    // Next-state of every register. The read ports sample regs_d rather
    // than regs_q, which gives same-edge forwarding for free, including
    // merged half-word / bit-set results.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wb_fire && (wbsel == SEL_W'(i))) begin
                regs_d[i] = wbdata;
            end
            if (regwen && (selwreg == SEL_W'(i))) begin
                regs_d[i] = p_merged;
            end
        end
        // Hardwired-zero register: writes discarded, reads return 0.
        if (ZERO_REG0) begin
            regs_d[0] = '0;
        end
    end

    always_comb begin
        outa_d    = outa_q;
        outb_d    = outb_q;
        rvalida_d = enrregA;
        rvalidb_d = enrregB;
        if (enrregA) begin
            outa_d = cnstA ? CNST_A : regs_d[seloutA];
        end
        if (enrregB) begin
            outb_d = cnstB ? CNST_B : regs_d[seloutB];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outa_q    <= '0;
            outb_q    <= '0;
            rvalida_q <= 1'b0;
            rvalidb_q <= 1'b0;
        end else begin
            outa_q    <= outa_d;
            outb_q    <= outb_d;
            rvalida_q <= rvalida_d;
            rvalidb_q <= rvalidb_d;
        end
    end

    assign outA    = outa_q;
    assign outB    = outb_q;
    assign rvalidA = rvalida_q;
    assign rvalidB = rvalidb_q;

endmodule

// File: tb/tb_reg_bank_p.sv
// Bench for reg_bank_p: two instances share one stimulus stream, one built
// with a normal register 0 and one with a hardwired-zero register 0.
// An array-level model predicts outputs; a negedge process compares every
// cycle, and directed steps add literal expectations.
module tb_reg_bank_p;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int SW    = 4;
    localparam logic [DW-1:0] BASE = 64'hAB0075C1_5600EB80;

    logic          clock = 1'b0;
    logic          reset;
    logic          regwen;
    logic [DW-1:0] inA;
    logic [SW-1:0] selwreg;
    logic [1:0]    endwreg;
    logic          wbvalid;
    logic [SW-1:0] wbsel;
    logic [DW-1:0] wbdata;
    logic [SW-1:0] seloutA, seloutB;
    logic          enrregA, enrregB, cnstA, cnstB;

    logic          wbready0, wbready1;
    logic [DW-1:0] outA0, outB0, outA1, outB1;
    logic          rvA0, rvB0, rvA1, rvB1;

    always #5 clock = ~clock;

    reg_bank_p #(.DATA_W(DW), .DEPTH(DEPTH), .ZERO_REG0(1'b0)) dut0 (
        .clock(clock), .reset(reset), .regwen(regwen), .inA(inA),
        .selwreg(selwreg), .endwreg(endwreg), .wbvalid(wbvalid),
        .wbsel(wbsel), .wbdata(wbdata), .wbready(wbready0),
        .seloutA(seloutA), .seloutB(seloutB), .enrregA(enrregA),
        .enrregB(enrregB), .cnstA(cnstA), .cnstB(cnstB),
        .outA(outA0), .outB(outB0), .rvalidA(rvA0), .rvalidB(rvB0)
    );

    reg_bank_p #(.DATA_W(DW), .DEPTH(DEPTH), .ZERO_REG0(1'b1)) dut1 (
        .clock(clock), .reset(reset), .regwen(regwen), .inA(inA),
        .selwreg(selwreg), .endwreg(endwreg), .wbvalid(wbvalid),
        .wbsel(wbsel), .wbdata(wbdata), .wbready(wbready1),
        .seloutA(seloutA), .seloutB(seloutB), .enrregA(enrregA),
        .enrregB(enrregB), .cnstA(cnstA), .cnstB(cnstB),
        .outA(outA1), .outB(outB1), .rvalidA(rvA1), .rvalidB(rvB1)
    );

    // Model state: index 0 = normal build, 1 = zero-register-0 build
    logic [DW-1:0] m_regs [2][DEPTH];
    logic [DW-1:0] m_outA [2];
    logic [DW-1:0] m_outB [2];
    logic          m_rvA, m_rvB;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] p_write(input logic [DW-1:0] old,
                                              input logic [DW-1:0] data,
                                              input logic [1:0] mode);
        logic [DW-1:0] lo_mask;
        lo_mask = 64'h00000000_FFFFFFFF;
        case (mode)
            2'd0:    return data;
            2'd1:    return (old & ~lo_mask) | (data & lo_mask);
            2'd2:    return (old & lo_mask) | (data & ~lo_mask);
            default: return old | data;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < DEPTH; r++) m_regs[k][r] = '0;
            m_outA[k] = '0;
            m_outB[k] = '0;
        end
        m_rvA = 1'b0;
        m_rvB = 1'b0;
    endtask

    // Predict the effect of the coming rising edge from the current inputs,
    // advance one clock, then publish the prediction.
    task automatic tick();
        logic [DW-1:0] nxt [2][DEPTH];
        logic [DW-1:0] a_n [2];
        logic [DW-1:0] b_n [2];
        bit acc;
        if (!reset) begin
            @(posedge clock);
            #1;
            model_reset();
        end else begin
            acc = wbvalid && !(regwen && selwreg == wbsel);
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < DEPTH; r++) nxt[k][r] = m_regs[k][r];
                if (acc) nxt[k][wbsel] = wbdata;
                if (regwen) nxt[k][selwreg] = p_write(m_regs[k][selwreg], inA, endwreg);
                if (k == 1) nxt[k][0] = '0;
                a_n[k] = enrregA ? (cnstA ? 64'd0 : nxt[k][seloutA]) : m_outA[k];
                b_n[k] = enrregB ? (cnstB ? 64'd1 : nxt[k][seloutB]) : m_outB[k];
            end
            @(posedge clock);
            #1;
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < DEPTH; r++) m_regs[k][r] = nxt[k][r];
                m_outA[k] = a_n[k];
                m_outB[k] = b_n[k];
            end
            m_rvA = enrregA;
            m_rvB = enrregB;
        end
    endtask

    task automatic idle();
        regwen = 0; inA = '0; selwreg = '0; endwreg = 2'd0;
        wbvalid = 0; wbsel = '0; wbdata = '0;
        seloutA = '0; seloutB = '0; enrregA = 0; enrregB = 0;
        cnstA = 0; cnstB = 0;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        logic exp_rdy;
        exp_rdy = reset && !(regwen && wbvalid && selwreg == wbsel);
        check("outA0", outA0, m_outA[0]);
        check("outB0", outB0, m_outB[0]);
        check("outA1", outA1, m_outA[1]);
        check("outB1", outB1, m_outB[1]);
        check("rvalidA0", {63'd0, rvA0}, {63'd0, m_rvA});
        check("rvalidB0", {63'd0, rvB0}, {63'd0, m_rvB});
        check("rvalidA1", {63'd0, rvA1}, {63'd0, m_rvA});
        check("rvalidB1", {63'd0, rvB1}, {63'd0, m_rvB});
        check("wbready0", {63'd0, wbready0}, {63'd0, exp_rdy});
        check("wbready1", {63'd0, wbready1}, {63'd0, exp_rdy});
    end

    initial begin
        reset = 1'b0;
        idle();
        model_reset();
        repeat (2) tick();
        check("rst_outA0", outA0, 64'd0);
        check("rst_wbready0", {63'd0, wbready0}, 64'd0);
        reset = 1'b1;

        // Fill all registers, then read each back on port B
        for (int i = 0; i < DEPTH; i++) begin
            regwen = 1; selwreg = SW'(i); endwreg = 2'd0;
            inA = BASE + 64'(16 * (i + 1));
            tick();
        end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            seloutB = SW'(i); enrregB = 1;
            tick();
            check("fill_outB0", outB0, BASE + 64'(16 * (i + 1)));
            check("fill_outB1", outB1, (i == 0) ? 64'd0 : BASE + 64'(16 * (i + 1)));
            check("fill_rvalidB", {63'd0, rvB0}, 64'd1);
        end
        idle();
        tick();
        check("rvalidB_drop", {63'd0, rvB0}, 64'd0);

        // Write modes on register 3, observed through forwarding on port A
        regwen = 1; selwreg = 4'd3; endwreg = 2'd0; inA = 64'h11112222_33334444;
        tick();
        seloutA = 4'd3; enrregA = 1;
        endwreg = 2'd1; inA = 64'hFFFFFFFF_AAAAAAAA;
        tick();
        check("mode_lo", outA0, 64'h11112222_AAAAAAAA);
        endwreg = 2'd2; inA = 64'hBBBBBBBB_00000000;
        tick();
        check("mode_hi", outA0, 64'hBBBBBBBB_AAAAAAAA);
        endwreg = 2'd3; inA = 64'h1;
        tick();
        check("mode_set", outA0, 64'hBBBBBBBB_AAAAAAAB);

        // Same-edge forwarding of a full write
        idle();
        regwen = 1; selwreg = 4'd5; inA = 64'hDEAD; seloutA = 4'd5; enrregA = 1;
        tick();
        check("forward", outA0, 64'hDEAD);

        // Collision: P wins, W stalls then lands
        idle();
        regwen = 1; selwreg = 4'd7; inA = 64'h1;
        wbvalid = 1; wbsel = 4'd7; wbdata = 64'h2;
        seloutA = 4'd7; enrregA = 1;
        #1;
        check("coll_ready", {63'd0, wbready0}, 64'd0);
        tick();
        check("coll_p_wins", outA0, 64'h1);
        regwen = 0;
        #1;
        check("coll_ready_up", {63'd0, wbready0}, 64'd1);
        tick();
        check("coll_w_lands", outA0, 64'h2);
        idle();
        regwen = 1; selwreg = 4'd8; inA = 64'h88;
        wbvalid = 1; wbsel = 4'd9; wbdata = 64'h99;
        #1;
        check("dual_ready", {63'd0, wbready0}, 64'd1);
        tick();
        idle();
        seloutA = 4'd8; seloutB = 4'd9; enrregA = 1; enrregB = 1;
        tick();
        check("dual_p", outA0, 64'h88);
        check("dual_w", outB0, 64'h99);

        // Constant injection and hold
        cnstA = 1; cnstB = 1;
        tick();
        check("cnstA", outA0, 64'd0);
        check("cnstB", outB0, 64'd1);
        idle();
        seloutA = 4'd2; seloutB = 4'd4;
        tick();
        check("holdA", outA0, 64'd0);
        check("holdB", outB0, 64'd1);

        // Register 0 behaviour in both builds
        idle();
        regwen = 1; selwreg = 4'd0; inA = 64'h55; seloutA = 4'd0; enrregA = 1;
        tick();
        check("r0_p_norm", outA0, 64'h55);
        check("r0_p_zero", outA1, 64'd0);
        idle();
        wbvalid = 1; wbsel = 4'd0; wbdata = 64'h55;
        #1;
        check("r0_w_ready", {63'd0, wbready1}, 64'd1);
        tick();
        idle();
        seloutA = 4'd0; enrregA = 1; seloutB = 4'd9; enrregB = 1;
        tick();
        check("r0_read_zero", outA1, 64'd0);
        check("r0_read_norm", outA0, 64'h55);

        // Asynchronous reset in the middle of a cycle with a W request pending
        wbvalid = 1; wbsel = 4'd10; wbdata = 64'hA10;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("arst_outA0", outA0, 64'd0);
        check("arst_outB0", outB0, 64'd0);
        check("arst_rvA0", {63'd0, rvA0}, 64'd0);
        check("arst_rvB1", {63'd0, rvB1}, 64'd0);
        check("arst_ready", {63'd0, wbready0}, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        idle();
        wbvalid = 1; wbsel = 4'd10; wbdata = 64'hA10;
        #1;
        check("post_rst_ready", {63'd0, wbready0}, 64'd1);
        tick();
        idle();
        seloutB = 4'd10; enrregB = 1; seloutA = 4'd9; enrregA = 1;
        tick();
        check("post_rst_w", outB0, 64'hA10);
        check("post_rst_clear", outA0, 64'd0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_p.md
Name: reg_bank_p

Overview:
Parametrised, dual-write-port successor of the 64x16 register bank feeding the ALU operand buses.
- Port P (host/testbench write) supports four write modes. Port W (ALU write-back) uses a valid/ready handshake.
- Two registered read ports (A, B) have load enables, constant injection and same-cycle write forwarding.
- A one-cycle valid flag accompanies each read port.

Parameters:
DATA_W, 64, register and bus width (even, >=8)
DEPTH, 16, number of registers (power of 2, >=2); SEL_W = $clog2(DEPTH) is a derived localparam
CNST_A, 0, value loaded into outA when cnstA=1
CNST_B, 1, value loaded into outB when cnstB=1
ZERO_REG0, 0, 1 = register 0 reads as 0 and ignores all writes

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
regwen  in  1  port P write enable
inA  in  DATA_W  port P write data
selwreg  in  SEL_W  port P target register
endwreg  in  2  port P write mode
wbvalid  in  1  port W write request
wbsel  in  SEL_W  port W target register
wbdata  in  DATA_W  port W write data
wbready  out  1  port W accept (combinational)
seloutA  in  SEL_W  read port A register select
seloutB  in  SEL_W  read port B register select
enrregA  in  1  load enable for outA
enrregB  in  1  load enable for outB
cnstA  in  1  load CNST_A instead of the register
cnstB  in  1  load CNST_B instead of the register
outA  out  DATA_W  registered operand A
outB  out  DATA_W  registered operand B
rvalidA  out  1  1 for one cycle after an outA load
rvalidB  out  1  1 for one cycle after an outB load

Behaviour:
Reset (reset=0, asynchronous):
- All DEPTH registers, outA, outB, rvalidA and rvalidB go to 0.
- wbready=0 while reset is asserted.

Port P write modes (endwreg), applied at the rising edge when regwen=1. Let H = DATA_W/2; r is the old register value.
- 00: full write, r <= inA.
- 01: low half, r[H-1:0] <= inA[H-1:0]; upper half held.
- 10: high half, r[DATA_W-1:H] <= inA[DATA_W-1:H]; lower half held.
- 11: bit-set, r <= r | inA.

Port W writes:
- A transfer occurs when wbvalid=1 and wbready=1; the write is always a full-word write.
- wbready = reset & ~(regwen & wbvalid & (selwreg==wbsel)).
- Same-target collision: port P wins. Port W is stalled and must hold wbsel/wbdata until accepted.
- Different targets: both ports write in the same cycle.

ZERO_REG0=1:
- Writes to register 0 from either port are discarded.
- A port W write to register 0 is still accepted (wbready=1 unless a collision).
- Reads of register 0 return 0.

Read ports (A shown; B is identical):
- On a rising edge with enrregA=1: outA <= CNST_A if cnstA=1, else the next-state value of register seloutA (forwarding).
- Forwarding: if a write to seloutA commits in the same edge, outA receives the post-write value, including the merged result for modes 01/10/11 and the port W data.
- enrregA=0: outA holds.
- rvalidA <= enrregA (registered), so latency is 1 cycle from select to outA.
- cnstA is ignored when enrregA=0.
- Both read ports may select the same register.

No state machine beyond the register array. All outputs except wbready are registered.

Reset mid-operation:
- An in-flight port W request is dropped.
- The requester must re-present it after reset deasserts; the first acceptance can occur in the first cycle with reset=1.

Decomposition:
- Shared package holds the mode constants WMODE_FULL=2'b00, WMODE_LO=2'b01, WMODE_HI=2'b10, WMODE_SET=2'b11.
- Package also holds the default DATA_W/DEPTH values shared with the ALU.
- One sub-module, reg_bank_wmerge: combinational function of (old value, inA, endwreg) producing the port P next value. It is used both for the array write and for the forwarding path.

Test Plan:
1. Reset, then full-write reg i with value 0xAB0075C1_5600EB80 + 16*(i+1) for i=0..15. Read each via B with cnstB=0, enrregB=1: outB matches one cycle later and rvalidB=1 for one cycle.
2. reg3=0x11112222_33334444:
   - mode 01 with inA=0xFFFFFFFF_AAAAAAAA gives 0x11112222_AAAAAAAA;
   - then mode 10 with inA=0xBBBBBBBB_00000000 gives 0xBBBBBBBB_AAAAAAAA;
   - then mode 11 with inA=0x1 gives 0xBBBBBBBB_AAAAAAAB.
3. Forwarding: same edge, regwen=1, selwreg=5, inA=0xDEAD, seloutA=5, enrregA=1 -> outA=0xDEAD next cycle, not the old value.
4. Collision:
   - regwen=1, selwreg=7, inA=0x1; wbvalid=1, wbsel=7, wbdata=0x2 -> wbready=0, reg7=0x1.
   - Next cycle regwen=0 -> wbready=1, reg7=0x2.
   - Non-colliding targets: both writes land.
5. Constants: cnstA=1, cnstB=1, enrregA=enrregB=1 -> outA=0, outB=1. Then enrregA=enrregB=0 with seloutA/B changed -> outputs hold.
6. ZERO_REG0=1 build: write 0x55 to reg0 via P and via W -> W accepted; reg0 reads 0. Then assert reset mid-run -> all outputs 0 immediately (asynchronous), wbready=0.
